// File: rtl/mig_u_mem_arbiter.sv
// Round-robin arbiter sharing the MigU single-port SRAM between instruction
// fetch and load/store, with 1-cycle read responses steered back to their owner.
module mig_u_mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_valid,
   input  logic [ADDR_WIDTH-3:0] if_req_addr,
   output logic                  if_req_ready,
   output logic                  if_rsp_valid,
   output logic [DATA_WIDTH-1:0] if_rsp_data,
   input  logic                  ls_req_valid,
   input  logic                  ls_req_we,
   input  logic [ADDR_WIDTH-3:0] ls_req_addr,
   input  logic [DATA_WIDTH-1:0] ls_req_wdata,
   input  logic [3:0]            ls_req_be,
   output logic                  ls_req_ready,
   output logic                  ls_rsp_valid,
   output logic [DATA_WIDTH-1:0] ls_rsp_data,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_LS = 1'b1;

   logic last_grant_q, last_grant_d;
   logic rsp_pending_q, rsp_pending_d;
   logic rsp_owner_q, rsp_owner_d;

   logic grant_ls;
   logic accept;

   // On a tie the requester that was not served last wins.
   assign grant_ls = ls_req_valid & (~if_req_valid | (last_grant_q == OWNER_IF));
   assign accept   = (if_req_valid | ls_req_valid) & mem_ready & ~rst;

   assign if_req_ready = accept & ~grant_ls;
   assign ls_req_ready = accept & grant_ls;

   assign mem_en    = accept;
   assign mem_we    = grant_ls & ls_req_we;
   assign mem_addr  = grant_ls ? ls_req_addr : if_req_addr;
   assign mem_wdata = grant_ls ? ls_req_wdata : '0;
   assign mem_be    = grant_ls ? ls_req_be : 4'b0000;

   always_comb begin
      last_grant_d  = last_grant_q;
      rsp_pending_d = 1'b0;
      rsp_owner_d   = rsp_owner_q;
      if (accept) begin
         last_grant_d  = grant_ls ? OWNER_LS : OWNER_IF;
         rsp_pending_d = 1'b1;
         rsp_owner_d   = grant_ls ? OWNER_LS : OWNER_IF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q  <= OWNER_LS;
         rsp_pending_q <= 1'b0;
         rsp_owner_q   <= OWNER_IF;
      end else begin
         last_grant_q  <= last_grant_d;
         rsp_pending_q <= rsp_pending_d;
         rsp_owner_q   <= rsp_owner_d;
      end
   end

   // Responses carry no backpressure, so the SRAM data goes straight to both owners.
   assign if_rsp_valid = rsp_pending_q & (rsp_owner_q == OWNER_IF);
   assign ls_rsp_valid = rsp_pending_q & (rsp_owner_q == OWNER_LS);
   assign if_rsp_data  = mem_rdata;
   assign ls_rsp_data  = mem_rdata;

endmodule

// File: tb/tb_mig_u_mem_arbiter.sv
// Self-checking bench for mig_u_mem_arbiter: directed vector table followed by
// randomized traffic checked against a transaction-level reference model.
module tb_mig_u_mem_arbiter;

   localparam int AW    = 14;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req_valid;
   logic [AW-1:0] if_req_addr;
   logic          if_req_ready;
   logic          if_rsp_valid;
   logic [31:0]   if_rsp_data;
   logic          ls_req_valid;
   logic          ls_req_we;
   logic [AW-1:0] ls_req_addr;
   logic [31:0]   ls_req_wdata;
   logic [3:0]    ls_req_be;
   logic          ls_req_ready;
   logic          ls_rsp_valid;
   logic [31:0]   ls_rsp_data;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_ready;
   logic [31:0]   mem_rdata;

   always #5 clk = ~clk;

   mig_u_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
      .ls_req_wdata(ls_req_wdata), .ls_req_be(ls_req_be), .ls_req_ready(ls_req_ready),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   // SRAM device model: 1-cycle read latency, byte-enabled writes.
   logic [31:0] sram [DEPTH];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   function automatic logic [31:0] init_word(input int i);
      return 32'hC0DE0000 ^ (i * 32'h00010101);
   endfunction

   typedef struct {
      logic          rst;
      logic          ifv;
      logic [AW-1:0] ifa;
      logic          lsv;
      logic          we;
      logic [AW-1:0] lsa;
      logic [31:0]   wd;
      logic [3:0]    be;
      logic          mr;
      logic          e_ifr;
      logic          e_lsr;
      logic          e_en;
      logic          e_ifrsp;
      logic          e_lsrsp;
      logic          chk_d;
      logic [31:0]   e_data;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic ifv, input int ifa,
                               input logic lsv, input logic we, input int lsa,
                               input logic [31:0] wd, input logic [3:0] be, input logic mr,
                               input logic eifr, input logic elsr, input logic een,
                               input logic eifrsp, input logic elsrsp,
                               input logic chkd, input logic [31:0] ed);
      vec_t v;
      v.rst = r; v.ifv = ifv; v.ifa = AW'(ifa); v.lsv = lsv; v.we = we; v.lsa = AW'(lsa);
      v.wd = wd; v.be = be; v.mr = mr; v.e_ifr = eifr; v.e_lsr = elsr; v.e_en = een;
      v.e_ifrsp = eifrsp; v.e_lsrsp = elsrsp; v.chk_d = chkd; v.e_data = ed;
      return v;
   endfunction

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a shadow memory plus "who was served last" and the one
   // response that is in flight to its owner.
   logic [31:0] ref_mem [DEPTH];
   bit          m_last_ls;
   bit          m_pv;
   bit          m_pls;
   bit          m_pread;
   logic [31:0] m_pdata;

   task automatic step(input vec_t v, input bit use_tbl, input int idx,
                       output bit acc_if, output bit acc_ls);
      bit          any_req, acc, serve_ls, n_read;
      logic [31:0] n_data;
      logic [AW-1:0] a;
      rst = v.rst; if_req_valid = v.ifv; if_req_addr = v.ifa;
      ls_req_valid = v.lsv; ls_req_we = v.we; ls_req_addr = v.lsa;
      ls_req_wdata = v.wd; ls_req_be = v.be; mem_ready = v.mr;
      #4;
      any_req = v.ifv || v.lsv;
      acc = any_req && v.mr && !v.rst;
      if (v.ifv && v.lsv) serve_ls = !m_last_ls;
      else                serve_ls = v.lsv;
      acc_if = acc && !serve_ls;
      acc_ls = acc && serve_ls;

      chk("if_req_ready", 32'(if_req_ready), 32'(acc_if));
      chk("ls_req_ready", 32'(ls_req_ready), 32'(acc_ls));
      chk("mem_en", 32'(mem_en), 32'(acc));
      if (acc) begin
         a = serve_ls ? v.lsa : v.ifa;
         chk("mem_addr", 32'(mem_addr), 32'(a));
         chk("mem_we", 32'(mem_we), 32'(serve_ls && v.we));
         if (!serve_ls) chk("mem_be_if", 32'(mem_be), 32'h0);
         if (serve_ls && v.we) begin
            chk("mem_be", 32'(mem_be), 32'(v.be));
            chk("mem_wdata", mem_wdata, v.wd);
         end
      end
      chk("if_rsp_valid", 32'(if_rsp_valid), 32'(m_pv && !m_pls));
      chk("ls_rsp_valid", 32'(ls_rsp_valid), 32'(m_pv && m_pls));
      if (m_pv && m_pread)
         chk(m_pls ? "ls_rsp_data" : "if_rsp_data", m_pls ? ls_rsp_data : if_rsp_data, m_pdata);

      if (use_tbl) begin
         chk("tbl_if_ready", 32'(if_req_ready), 32'(v.e_ifr));
         chk("tbl_ls_ready", 32'(ls_req_ready), 32'(v.e_lsr));
         chk("tbl_mem_en", 32'(mem_en), 32'(v.e_en));
         chk("tbl_if_rsp", 32'(if_rsp_valid), 32'(v.e_ifrsp));
         chk("tbl_ls_rsp", 32'(ls_rsp_valid), 32'(v.e_lsrsp));
         if (v.chk_d)
            chk("tbl_rsp_data", v.e_ifrsp ? if_rsp_data : ls_rsp_data, v.e_data);
         $display("vec %0d: rst=%b if_rdy=%b ls_rdy=%b en=%b if_rsp=%b ls_rsp=%b",
                  idx, v.rst, if_req_ready, ls_req_ready, mem_en, if_rsp_valid, ls_rsp_valid);
      end

      n_read = 1'b0;
      n_data = '0;
      if (acc) begin
         a = serve_ls ? v.lsa : v.ifa;
         n_read = !(serve_ls && v.we);
         n_data = ref_mem[a];
         if (!n_read)
            for (int b = 0; b < 4; b++)
               if (v.be[b]) ref_mem[a][b*8 +: 8] = v.wd[b*8 +: 8];
      end

      @(posedge clk);
      #1;
      if (v.rst) begin
         m_last_ls = 1'b1;
         m_pv      = 1'b0;
      end else begin
         if (acc) m_last_ls = serve_ls;
         m_pv    = acc;
         m_pls   = serve_ls;
         m_pread = n_read;
         m_pdata = n_data;
      end
   endtask

   vec_t tbl[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t r;
      bit   ai, al, prev_ai, prev_al;

      for (int i = 0; i < DEPTH; i++) begin
         sram[i]    = init_word(i);
         ref_mem[i] = init_word(i);
      end
      mem_rdata = '0;
      m_last_ls = 1'b1; m_pv = 1'b0; m_pls = 1'b0; m_pread = 1'b0; m_pdata = '0;

      //                rst ifv ifa  lsv we lsa   wdata          be    mr  ifr lsr en ifrsp lsrsp chkd data
      tbl.push_back(mk(1, 1, 0,    1, 0, 0,    32'h0,         4'h0, 1,  0, 0, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 0,    0, 0, 0,    32'h0,         4'h0, 1,  0, 0, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 1, 0,    0, 0, 0,    32'h0,         4'h0, 1,  1, 0, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 1, 1,    0, 0, 0,    32'h0,         4'h0, 1,  1, 0, 1, 1, 0, 1, init_word(0)));
      tbl.push_back(mk(0, 1, 2,    0, 0, 0,    32'h0,         4'h0, 1,  1, 0, 1, 1, 0, 1, init_word(1)));
      tbl.push_back(mk(0, 1, 3,    0, 0, 0,    32'h0,         4'h0, 1,  1, 0, 1, 1, 0, 1, init_word(2)));
      tbl.push_back(mk(0, 0, 0,    0, 0, 0,    32'h0,         4'h0, 1,  0, 0, 0, 1, 0, 1, init_word(3)));
      tbl.push_back(mk(1, 0, 0,    0, 0, 0,    32'h0,         4'h0, 1,  0, 0, 0, 0, 0, 0, 32'h0));
      // contention from reset: IF, LSU, IF, LSU
      tbl.push_back(mk(0, 1, 8,    1, 0, 5,    32'h0,         4'h0, 1,  1, 0, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 1, 8,    1, 0, 5,    32'h0,         4'h0, 1,  0, 1, 1, 1, 0, 1, init_word(8)));
      tbl.push_back(mk(0, 1, 8,    1, 0, 5,    32'h0,         4'h0, 1,  1, 0, 1, 0, 1, 1, init_word(5)));
      tbl.push_back(mk(0, 1, 8,    1, 0, 5,    32'h0,         4'h0, 1,  0, 1, 1, 1, 0, 1, init_word(8)));
      tbl.push_back(mk(0, 0, 0,    0, 0, 0,    32'h0,         4'h0, 1,  0, 0, 0, 0, 1, 1, init_word(5)));
      // LSU write then IF read of the same word
      tbl.push_back(mk(0, 0, 0,    1, 1, 16,   32'hDEADBEEF,  4'hF, 1,  0, 1, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 1, 16,   0, 0, 0,    32'h0,         4'h0, 1,  1, 0, 1, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0,    0, 0, 0,    32'h0,         4'h0, 1,  0, 0, 0, 1, 0, 1, 32'hDEADBEEF));
      // stall with last grant = LSU, then IF goes first
      tbl.push_back(mk(0, 0, 0,    1, 0, 16,   32'h0,         4'h0, 1,  0, 1, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 1, 32,   1, 0, 33,   32'h0,         4'h0, 0,  0, 0, 0, 0, 1, 1, 32'hDEADBEEF));
      tbl.push_back(mk(0, 1, 32,   1, 0, 33,   32'h0,         4'h0, 0,  0, 0, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 1, 32,   1, 0, 33,   32'h0,         4'h0, 0,  0, 0, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 1, 32,   1, 0, 33,   32'h0,         4'h0, 1,  1, 0, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 1, 32,   1, 0, 33,   32'h0,         4'h0, 1,  0, 1, 1, 1, 0, 1, init_word(32)));
      tbl.push_back(mk(0, 0, 0,    0, 0, 0,    32'h0,         4'h0, 1,  0, 0, 0, 0, 1, 1, init_word(33)));
      // byte-enable write touches byte 1 only
      tbl.push_back(mk(0, 0, 0,    1, 1, 16,   32'h0000AB00,  4'h2, 1,  0, 1, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0,    1, 0, 16,   32'h0,         4'h0, 1,  0, 1, 1, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0,    0, 0, 0,    32'h0,         4'h0, 1,  0, 0, 0, 0, 1, 1, 32'hDEADABEF));
      // reset the cycle after an LSU read accept
      tbl.push_back(mk(0, 0, 0,    1, 0, 3,    32'h0,         4'h0, 1,  0, 1, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(1, 1, 4,    1, 0, 6,    32'h0,         4'h0, 1,  0, 0, 0, 0, 1, 1, init_word(3)));
      tbl.push_back(mk(0, 1, 4,    1, 0, 6,    32'h0,         4'h0, 1,  1, 0, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0,    0, 0, 0,    32'h0,         4'h0, 1,  0, 0, 0, 1, 0, 1, init_word(4)));
      // reset after an IF grant must still hand the next tie to IF
      tbl.push_back(mk(0, 1, 7,    0, 0, 0,    32'h0,         4'h0, 1,  1, 0, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 0,    0, 0, 0,    32'h0,         4'h0, 1,  0, 0, 0, 1, 0, 1, init_word(7)));
      tbl.push_back(mk(0, 1, 4,    1, 0, 6,    32'h0,         4'h0, 1,  1, 0, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0,    0, 0, 0,    32'h0,         4'h0, 1,  0, 0, 0, 1, 0, 1, init_word(4)));

      @(posedge clk);
      #1;
      foreach (tbl[i]) step(tbl[i], 1'b1, i, ai, al);

      // Random traffic: requesters hold their payload until accepted.
      r = tbl[0];
      r.ifv = 1'b0; r.lsv = 1'b0;
      prev_ai = 1'b0; prev_al = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!r.ifv || prev_ai) begin
            r.ifv = ($urandom_range(0, 3) != 0);
            r.ifa = AW'($urandom_range(0, 15));
         end
         if (!r.lsv || prev_al) begin
            r.lsv = ($urandom_range(0, 3) != 0);
            r.we  = $urandom_range(0, 1) != 0;
            r.lsa = AW'($urandom_range(0, 15));
            r.wd  = $urandom;
            r.be  = 4'($urandom_range(0, 15));
         end
         r.mr  = ($urandom_range(0, 4) != 0);
         r.rst = ($urandom_range(0, 49) == 0);
         step(r, 1'b0, c, prev_ai, prev_al);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mig_u_mem_arbiter.md
# mig_u_mem_arbiter

Two-requester arbiter that shares the single synchronous SRAM port of the MigU core between instruction fetch (IF) and load/store (LSU). It sits inside `MigUCore`, between the fetch/LSU stages and the unified instruction/data memory. It grants one request per cycle with round-robin fairness and steers each 1-cycle-latency read response back to its owner. It keeps the full pipelined throughput of one access per cycle.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: byte address width of the core. The word address width is `ADDR_WIDTH-2`.
- `DATA_WIDTH`, default 32: word width. Must be 32.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `if_req_valid`  in  1  IF read request.
- `if_req_addr`  in  ADDR_WIDTH-2  IF word address.
- `if_req_ready`  out  1  IF request accepted this cycle.
- `if_rsp_valid`  out  1  IF read data valid.
- `if_rsp_data`  out  32  IF read data.
- `ls_req_valid`  in  1  LSU request.
- `ls_req_we`  in  1  1 = write, 0 = read.
- `ls_req_addr`  in  ADDR_WIDTH-2  LSU word address.
- `ls_req_wdata`  in  32  write data.
- `ls_req_be`  in  4  byte enables for writes. Ignored on reads.
- `ls_req_ready`  out  1  LSU request accepted this cycle.
- `ls_rsp_valid`  out  1  LSU response: read data, or write acknowledge.
- `ls_rsp_data`  out  32  LSU read data. Value is don't-care for write acks.
- `mem_en`  out  1  SRAM access strobe.
- `mem_we`  out  1  SRAM write.
- `mem_addr`  out  ADDR_WIDTH-2  SRAM word address.
- `mem_wdata`  out  32  SRAM write data.
- `mem_be`  out  4  SRAM byte enables.
- `mem_ready`  in  1  SRAM can accept an access this cycle.
- `mem_rdata`  in  32  SRAM read data. Valid exactly one cycle after an accepted `mem_en`.

## Operation
- Handshake: a request is accepted in a cycle when `*_req_valid & *_req_ready`. Requesters hold valid and payload stable until accepted.
- Grant logic is combinational in the current cycle:
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester not in `last_grant`.
- `*_req_ready = winner & mem_ready & !rst`. The loser's ready is 0.
- `mem_en = (if_req_valid | ls_req_valid) & mem_ready & !rst`.
  - `mem_addr`, `mem_we`, `mem_wdata`, `mem_be` are muxed from the winner.
  - On an IF grant, `mem_we=0` and `mem_be=4'b0000`.
- State registers:
  - `last_grant` (0 = IF, 1 = LSU). Updated only on an accepted request.
  - `rsp_pending` (1 bit) and `rsp_owner` (1 bit). Set from the accepted request, cleared when no request is accepted.
- Response routing:
  - `if_rsp_valid = rsp_pending & rsp_owner==IF`.
  - `ls_rsp_valid = rsp_pending & rsp_owner==LSU`. This covers both reads and writes.
  - Both `*_rsp_data` outputs are driven from `mem_rdata`.
- Responses have no backpressure. Requesters must consume them in the cycle they are presented.
- Ordering: accesses reach the SRAM in grant order. An LSU write granted before an IF read of the same address is visible to that read.
- Reset values:
  - `last_grant=1`, so IF wins the first tie.
  - `rsp_pending=0`; `if_rsp_valid=ls_rsp_valid=0`.
  - `if_req_ready=ls_req_ready=mem_en=0` while `rst` is high.

## Timing
- Request accepted in cycle N → `mem_en` high in cycle N (same cycle, combinational) → `*_rsp_valid` high in cycle N+1.
- Throughput: one access per cycle. Back-to-back grants produce back-to-back responses.
- Contention: when both requesters are continuously valid, grants alternate every cycle (IF, LSU, IF, …). Neither requester waits more than 1 cycle.
- `mem_ready=0` in cycle N:
  - No grant is made and `last_grant` is unchanged.
  - `rsp_pending` in N+1 is 0.
  - A request outstanding from N-1 still responds in N.
- Reset mid-operation:
  - `rst` high in cycle R blocks any accept in R.
  - A response for a request accepted in R-1 is still presented in R.
  - From R+1 onward, all state is at its reset value.
- Request valid but not ready: no state change and no SRAM access for that requester.

## Test plan
- Reset then IF-only stream: IF valid at addresses 0x0000..0x0003 for 4 cycles, `mem_ready=1` → `if_req_ready` high each cycle, `mem_en` high 4 cycles, `if_rsp_valid` in cycles N+1..N+4 with SRAM data; `ls_rsp_valid` stays 0.
- Simultaneous contention from reset: both valid for 4 cycles → grants IF, LSU, IF, LSU; responses are owner-tagged in the same order, each one cycle after its grant.
- LSU write then IF read of the same address: write 0xDEADBEEF with `be=4'hF` to 0x0010, then IF read of 0x0010 → `ls_rsp_valid` ack, followed by `if_rsp_data=0xDEADBEEF`.
- Memory stall: `mem_ready=0` for 3 cycles with both requesters valid → no readies and no `mem_en`; after release, IF is granted first if `last_grant=LSU`.
- Byte-enable write: LSU write with `be=4'b0010` and `wdata=0x0000AB00` → `mem_be=4'b0010`, `mem_we=1`; a subsequent read returns only byte 1 changed.
- Reset mid-stream: `rst` asserted in the cycle after an LSU read accept → `ls_rsp_valid` still presented in the `rst` cycle, no accepts during `rst`, all responses 0 afterwards, and the next tie goes to IF.
